instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage sitting directly downstream of the program counter.
- Takes the current PC, issues one instruction-memory read at a time using a req/gnt/rvalid handshake, and registers the returned word into the IF/ID output register with a valid/ready handshake.
- Drives the PC stall input so the PC advances only once its address has been granted by memory.
- Handles branch flushes by discarding in-flight or stale fetches.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction word width.

Ports:
- i_clk  in  1  clock, all state updates on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pc  in  ADDR_W  current PC value.
- o_pc_stall  out  1  to PC stall input; 0 = PC may load its next value this edge.
- i_flush  in  1  branch taken this cycle; PC loads the branch target on the same edge.
- o_imem_req  out  1  memory read request.
- o_imem_addr  out  ADDR_W  request address.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  read data valid; exactly one per grant, at least 1 cycle after grant.
- i_imem_rdata  in  DATA_W  read data.
- o_instr_valid  out  1  IF/ID register holds a valid instruction.
- o_instr  out  DATA_W  fetched instruction.
- o_instr_pc  out  ADDR_W  address of o_instr.
- i_id_ready  in  1  decode accepts o_instr this edge when o_instr_valid=1.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; o_imem_req=0; o_instr_valid=0; o_instr=0; o_instr_pc=0; o_imem_addr=0; discard flag=0.
  - o_pc_stall=1 while in reset and in IDLE.
  - Reset mid-transaction abandons it; any later rvalid from that transaction is ignored while in IDLE.
- States: IDLE, REQ, WAIT, HOLD. At most one outstanding request.
- IDLE: always moves to REQ on the next edge after reset release.
- REQ:
  - o_imem_req=1, o_imem_addr=i_pc (combinational from i_pc).
  - On req&&gnt: capture the address into a pending-PC register and go to WAIT.
  - o_pc_stall=~(i_imem_gnt) in REQ, so the PC advances exactly on the grant edge. It is 1 in all other states except when a flush is active.
- WAIT:
  - o_imem_req=0.
  - On i_imem_rvalid with discard=0: o_instr<=rdata, o_instr_pc<=pending PC, o_instr_valid<=1, go to REQ.
  - On i_imem_rvalid with discard=1: drop the data, clear discard, go to REQ.
- REQ entry rule: REQ is entered only if the output register is empty or is being consumed (o_instr_valid&&i_id_ready) on that edge. Otherwise go to HOLD.
- HOLD: o_imem_req=0; on i_id_ready go to REQ.
- Output handshake:
  - o_instr_valid is cleared on an i_id_ready edge unless a new word is loaded on the same edge.
  - o_instr and o_instr_pc are held stable while valid&&!ready.
- Best-case throughput: one instruction per 2 cycles with 1-cycle memory latency (REQ/grant, then WAIT/rvalid).
- Flush (i_flush=1), highest priority:
  - Forces o_pc_stall=0 so the PC takes the branch target.
  - Clears o_instr_valid on that edge.
  - REQ without grant: the request is withdrawn; stay in REQ, next cycle present the new PC.
  - REQ with grant on the same cycle, or in WAIT without rvalid: set discard=1, go/stay WAIT.
  - WAIT with rvalid on the same cycle: drop the data, go to REQ.
  - HOLD: go to REQ.
  - IDLE: flush is ignored for state; IDLE still moves to REQ.
- Address arithmetic: none in this block; PC+4 is produced by the PC. o_imem_addr is passed through unmodified, including wrap at 0xFFFF_FFFC.
- Simultaneous i_id_ready and rvalid in WAIT: the old word is consumed and the new word is loaded on the same edge; o_instr_valid stays 1.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHECK_EN.
- When defined:
  - Adds output port o_misalign (1 bit, reset 0).
  - In REQ, if i_pc[1:0]!=0, no memory request is issued. Instead o_instr_valid<=1, o_instr<=32'h00000013 (NOP), o_instr_pc<=i_pc, o_misalign<=1, and o_pc_stall stays 1 until a flush.
  - o_misalign clears on flush or reset.
- When undefined: no port is present, and the low address bits are passed to memory unchecked.

Test Plan:
- Reset release, i_pc=0x0, gnt in the same cycle as req, rvalid 1 cycle later with rdata=0x00500093, i_id_ready=1 -> o_instr_valid=1 with o_instr=0x00500093 and o_instr_pc=0x0; o_pc_stall=0 only on the grant cycle.
- i_id_ready=0 for 5 cycles after the first instruction -> state HOLD, o_imem_req=0, o_instr and o_instr_pc stable, o_pc_stall=1. Raising ready -> a request for i_pc=0x4 is issued the next cycle.
- Flush in WAIT (request 0x8 outstanding), branch target 0x100 -> response for 0x8 dropped (o_instr_valid stays 0); next request address=0x100.
- Flush in REQ with i_imem_gnt=0 -> no discard; next cycle o_imem_addr=new PC; the first delivered o_instr_pc equals the new PC.
- Async reset asserted mid-WAIT, late rvalid arriving during IDLE -> o_instr_valid stays 0; fetch resumes at i_pc after release.
- With IFETCH_MISALIGN_CHECK_EN defined, i_pc=0x102 -> no o_imem_req; o_misalign=1, o_instr=0x00000013, o_instr_pc=0x102; a flush clears o_misalign.

Source files
------------

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage sitting directly behind the program counter. Issues one
// instruction-memory read at a time over a req/gnt/rvalid handshake and
// registers the returned word into the IF/ID register (valid/ready towards
// decode). The PC is allowed to advance only on the edge its address is
// granted, and a branch flush discards any in-flight or stale fetch.
//
// Optional feature (macro IFETCH_MISALIGN_CHECK_EN):
//   adds o_misalign; a PC with non-zero low bits is not sent to memory,
//   a NOP tagged with that PC is delivered instead and fetch stalls until
//   the next flush.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_pc               current PC
//   o_pc_stall         0 = PC may load its next value this edge
//   i_flush            branch taken; PC loads the target on the same edge
//   o_imem_req/addr    memory read request and address
//   i_imem_gnt         request accepted this cycle
//   i_imem_rvalid/rdata read data return (one per grant)
//   o_instr_valid      IF/ID register holds a valid instruction
//   o_instr/o_instr_pc fetched instruction and its address
//   i_id_ready         decode accepts o_instr this edge
//   o_misalign         (optional) misaligned PC detected
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_pc,
   output logic              o_pc_stall,
   input  logic              i_flush,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic              i_imem_gnt,
   input  logic              i_imem_rvalid,
   input  logic [DATA_W-1:0] i_imem_rdata,
`ifdef IFETCH_MISALIGN_CHECK_EN
   output logic              o_misalign,
`endif
   output logic              o_instr_valid,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_instr_pc,
   input  logic              i_id_ready
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_e;

   state_e            state_q, state_d;
   logic              discard_q, discard_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
`ifdef IFETCH_MISALIGN_CHECK_EN
   localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);
   logic              misalign_q, misalign_d;
`endif

   // The output register can take a new word if it is empty or its current
   // word is being consumed on this edge. A request is only issued when this
   // holds, so the single-entry register can never be overrun by a return.
   logic out_free;
   assign out_free = !instr_valid_q || i_id_ready;

   always_comb begin
      // NOTE: every signal driven here is given a default first, so no path
      // through the case leaves it unassigned and no latch is inferred.
      state_d       = state_q;
      discard_d     = discard_q;
      pend_pc_d     = pend_pc_q;
      instr_valid_d = instr_valid_q && !i_id_ready;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
      misalign_d    = misalign_q;
`endif
      o_imem_req    = 1'b0;
      o_imem_addr   = '0;
      o_pc_stall    = 1'b1;

      unique case (state_q)
         ST_IDLE: state_d = ST_REQ;

         ST_REQ: begin
            o_imem_addr = i_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (misalign_q || i_pc[1:0] != 2'b00) begin
               // Report once, then sit here with the PC stalled until a flush.
               if (!misalign_q && !i_flush) begin
                  if (out_free) begin
                     instr_valid_d = 1'b1;
                     instr_d       = NOP;
                     instr_pc_d    = i_pc;
                     misalign_d    = 1'b1;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end
            end else
`endif
            // A flush empties the output register, so it also frees it.
            if (out_free || i_flush) begin
               o_imem_req = 1'b1;
               o_pc_stall = ~i_imem_gnt;
               if (i_imem_gnt) begin
                  pend_pc_d = i_pc;
                  // Granted on the flush edge: the word belongs to the old path.
                  discard_d = i_flush;
                  state_d   = ST_WAIT;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end

         ST_WAIT: begin
            if (i_imem_rvalid) begin
               discard_d = 1'b0;
               state_d   = ST_REQ;
               if (!discard_q && !i_flush) begin
                  instr_valid_d = 1'b1;
                  instr_d       = i_imem_rdata;
                  instr_pc_d    = pend_pc_q;
               end
            end else if (i_flush) begin
               discard_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (i_id_ready || i_flush) state_d = ST_REQ;
         end
      endcase

      // Flush outranks everything above; IDLE keeps the PC stalled.
      if (i_flush) begin
         instr_valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
         misalign_d    = 1'b0;
`endif
         if (state_q != ST_IDLE) o_pc_stall = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         discard_q     <= 1'b0;
         pend_pc_q     <= '0;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
`ifdef IFETCH_MISALIGN_CHECK_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge values computed by the combinational block.
         state_q       <= state_d;
         discard_q     <= discard_d;
         pend_pc_q     <= pend_pc_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
`ifdef IFETCH_MISALIGN_CHECK_EN
         misalign_q    <= misalign_d;
`endif
      end
   end

   assign o_instr_valid = instr_valid_q;
   assign o_instr       = instr_q;
   assign o_instr_pc    = instr_pc_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
   assign o_misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Environment: a PC model (advances by 4 or loads the branch target when not
// stalled), an instruction memory with programmable latency, and a scoreboard
// that records every granted address and checks each word decode accepts.
// Scenario tasks drive stimulus on the falling edge and sample there too.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc = '0;
   logic        flush;
   logic [31:0] target;
   logic        gnt_en;
   logic        ready;
   logic        pc_force;
   logic [31:0] pc_force_val;
   int          lat;

   logic        o_pc_stall, o_imem_req, o_instr_valid;
   logic [31:0] o_imem_addr, o_instr, o_instr_pc;
   logic        imem_gnt;
`ifdef IFETCH_MISALIGN_CHECK_EN
   logic        o_misalign;
`endif

   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata  = '0;
   logic [31:0] mem_addr   = '0;
   logic        mem_busy   = 1'b0;
   int          mem_cnt    = 0;
   int          n_grants   = 0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   assign imem_gnt = o_imem_req && gnt_en;

   instr_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_pc          (pc),
      .o_pc_stall    (o_pc_stall),
      .i_flush       (flush),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (imem_gnt),
      .i_imem_rvalid (mem_rvalid),
      .i_imem_rdata  (mem_rdata),
`ifdef IFETCH_MISALIGN_CHECK_EN
      .o_misalign    (o_misalign),
`endif
      .o_instr_valid (o_instr_valid),
      .o_instr       (o_instr),
      .o_instr_pc    (o_instr_pc),
      .i_id_ready    (ready)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hC0DE_0013);
   endfunction

   // PC model
   always @(posedge clk) begin
      if (pc_force)         pc <= pc_force_val;
      else if (!o_pc_stall) pc <= flush ? target : pc + 32'd4;
   end

   // Memory model: rvalid exactly lat cycles after the grant; not reset.
   always @(posedge clk) begin
      mem_rvalid <= 1'b0;
      if (mem_busy) begin
         if (mem_cnt == 0) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem_word(mem_addr);
            mem_busy   <= 1'b0;
         end else begin
            mem_cnt <= mem_cnt - 1;
         end
      end
      if (o_imem_req && imem_gnt) begin
         n_grants <= n_grants + 1;
         if (lat <= 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem_word(o_imem_addr);
         end else begin
            mem_busy <= 1'b1;
            mem_cnt  <= lat - 2;
            mem_addr <= o_imem_addr;
         end
      end
   end

   // Scoreboard: push on grant, pop when decode accepts a word.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (o_instr_valid && ready && !flush) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no word", o_instr_pc, o_instr);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (o_instr !== e.data || o_instr_pc !== e.pc) begin
                  bad++;
                  $display("FAIL sb_word: got pc=%h instr=%h, expected pc=%h instr=%h",
                           o_instr_pc, o_instr, e.pc, e.data);
               end
            end
         end
         if (flush) exp_q.delete();
         else if (o_imem_req && imem_gnt) exp_q.push_back('{pc: o_imem_addr, data: mem_word(o_imem_addr)});
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Park the fetch in REQ at address v with the output register drained.
   task automatic set_pc(input logic [31:0] v);
      gnt_en       = 1'b0;
      ready        = 1'b1;
      pc_force     = 1'b1;
      pc_force_val = v;
      step();
      step();
      pc_force     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      #1;
      total++; if (o_imem_req !== 1'b0)    begin bad++; $display("FAIL rst_req: got %b expected 0", o_imem_req); end
      total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", o_instr_valid); end
      total++; if (o_instr !== 32'h0)      begin bad++; $display("FAIL rst_instr: got %h expected 0", o_instr); end
      total++; if (o_instr_pc !== 32'h0)   begin bad++; $display("FAIL rst_instr_pc: got %h expected 0", o_instr_pc); end
      total++; if (o_imem_addr !== 32'h0)  begin bad++; $display("FAIL rst_addr: got %h expected 0", o_imem_addr); end
      total++; if (o_pc_stall !== 1'b1)    begin bad++; $display("FAIL rst_stall: got %b expected 1", o_pc_stall); end
   endtask

   task automatic test_first_fetch();
      rst_n = 1'b1;
      #1;
      total++; if (o_pc_stall !== 1'b1) begin bad++; $display("FAIL ff_idle_stall: got %b expected 1", o_pc_stall); end
      step();  // IDLE -> REQ
      #1;
      total++; if (o_imem_req !== 1'b1)   begin bad++; $display("FAIL ff_req: got %b expected 1", o_imem_req); end
      total++; if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL ff_addr: got %h expected 0", o_imem_addr); end
      total++; if (o_pc_stall !== 1'b0)   begin bad++; $display("FAIL ff_grant_stall: got %b expected 0", o_pc_stall); end
      step();  // granted -> WAIT
      #1;
      total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL ff_wait_req: got %b expected 0", o_imem_req); end
      total++; if (o_pc_stall !== 1'b1) begin bad++; $display("FAIL ff_wait_stall: got %b expected 1", o_pc_stall); end
      step();  // rvalid -> word loaded
      ready = 1'b0;
      #1;
      total++; if (o_instr_valid !== 1'b1)     begin bad++; $display("FAIL ff_valid: got %b expected 1", o_instr_valid); end
      total++; if (o_instr !== 32'h0050_0093)  begin bad++; $display("FAIL ff_instr: got %h expected 00500093", o_instr); end
      total++; if (o_instr_pc !== 32'h0)       begin bad++; $display("FAIL ff_instr_pc: got %h expected 0", o_instr_pc); end
      total++; if (o_imem_req !== 1'b0)        begin bad++; $display("FAIL ff_full_req: got %b expected 0", o_imem_req); end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         step();
         #1;
         total++;
         if (o_imem_req !== 1'b0 || o_pc_stall !== 1'b1 || o_instr_valid !== 1'b1 ||
             o_instr !== 32'h0050_0093 || o_instr_pc !== 32'h0) begin
            bad++;
            $display("FAIL hold_c%0d: got req=%b stall=%b valid=%b instr=%h pc=%h, expected 0 1 1 00500093 0",
                     i, o_imem_req, o_pc_stall, o_instr_valid, o_instr, o_instr_pc);
         end
      end
      ready = 1'b1;
      step();
      #1;
      total++; if (o_imem_req !== 1'b1)   begin bad++; $display("FAIL hold_resume_req: got %b expected 1", o_imem_req); end
      total++; if (o_imem_addr !== 32'h4) begin bad++; $display("FAIL hold_resume_addr: got %h expected 4", o_imem_addr); end
   endtask

   task automatic test_back_to_back();
      int n0;
      n0 = n_grants;
      repeat (20) step();
      total++;
      if (n_grants - n0 !== 10) begin
         bad++;
         $display("FAIL b2b_rate: got %0d grants in 20 cycles, expected 10", n_grants - n0);
      end
   endtask

   task automatic test_flush_wait();
      int seen_valid;
      bit got_req;
      set_pc(32'h8);
      #1;
      total++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8) begin bad++; $display("FAIL fw_pre: got req=%b addr=%h expected 1 8", o_imem_req, o_imem_addr); end
      lat    = 3;
      gnt_en = 1'b1;
      step();  // 0x8 granted, now WAIT
      flush  = 1'b1;
      target = 32'h100;
      #1;
      total++; if (o_pc_stall !== 1'b0) begin bad++; $display("FAIL fw_stall: got %b expected 0", o_pc_stall); end
      step();
      flush = 1'b0;
      seen_valid = 0;
      got_req    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (o_instr_valid !== 1'b0) seen_valid++;
         if (o_imem_req === 1'b1) begin got_req = 1'b1; break; end
         step();
      end
      total++; if (seen_valid !== 0)       begin bad++; $display("FAIL fw_dropped: got %0d valid cycles expected 0", seen_valid); end
      total++; if (got_req !== 1'b1)       begin bad++; $display("FAIL fw_timeout: got no request, expected one"); end
      total++; if (o_imem_addr !== 32'h100) begin bad++; $display("FAIL fw_addr: got %h expected 100", o_imem_addr); end
      lat = 1;
      for (int i = 0; i < 10 && o_instr_valid !== 1'b1; i++) step();
      total++; if (o_instr_pc !== 32'h100) begin bad++; $display("FAIL fw_first_pc: got %h expected 100", o_instr_pc); end
   endtask

   task automatic test_flush_req();
      set_pc(32'h20);
      flush  = 1'b1;
      target = 32'h200;
      #1;
      total++; if (o_pc_stall !== 1'b0) begin bad++; $display("FAIL fr_stall: got %b expected 0", o_pc_stall); end
      step();
      flush = 1'b0;
      #1;
      total++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h200) begin bad++; $display("FAIL fr_addr: got req=%b addr=%h expected 1 200", o_imem_req, o_imem_addr); end
      gnt_en = 1'b1;
      for (int i = 0; i < 10 && o_instr_valid !== 1'b1; i++) step();
      total++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h200) begin bad++; $display("FAIL fr_first_pc: got valid=%b pc=%h expected 1 200", o_instr_valid, o_instr_pc); end
   endtask

   task automatic test_reset_mid_wait();
      set_pc(32'h40);
      lat    = 4;
      gnt_en = 1'b1;
      step();  // 0x40 granted, now WAIT
      rst_n        = 1'b0;
      pc_force     = 1'b1;
      pc_force_val = 32'h300;
      #1;
      total++; if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b0 || o_pc_stall !== 1'b1) begin bad++; $display("FAIL rw_in_reset: got valid=%b req=%b stall=%b expected 0 0 1", o_instr_valid, o_imem_req, o_pc_stall); end
      repeat (3) step();
      rst_n = 1'b1;  // late rvalid lands on the IDLE edge
      #1;
      total++; if (o_pc_stall !== 1'b1) begin bad++; $display("FAIL rw_idle_stall: got %b expected 1", o_pc_stall); end
      step();
      pc_force = 1'b0;
      lat      = 1;
      #1;
      total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL rw_late_rvalid: got valid=%b expected 0", o_instr_valid); end
      total++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h300) begin bad++; $display("FAIL rw_resume: got req=%b addr=%h expected 1 300", o_imem_req, o_imem_addr); end
      for (int i = 0; i < 10 && o_instr_valid !== 1'b1; i++) step();
      total++; if (o_instr_pc !== 32'h300 || o_instr !== mem_word(32'h300)) begin bad++; $display("FAIL rw_first: got pc=%h instr=%h expected 300 %h", o_instr_pc, o_instr, mem_word(32'h300)); end
   endtask

`ifdef IFETCH_MISALIGN_CHECK_EN
   task automatic test_misalign();
      set_pc(32'h100);
      ready        = 1'b0;
      pc_force     = 1'b1;
      pc_force_val = 32'h102;
      step();
      pc_force = 1'b0;
      #1;
      total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL ma_req: got %b expected 0", o_imem_req); end
      step();
      #1;
      total++;
      if (o_misalign !== 1'b1 || o_instr_valid !== 1'b1 || o_instr !== 32'h13 ||
          o_instr_pc !== 32'h102 || o_pc_stall !== 1'b1) begin
         bad++;
         $display("FAIL ma_nop: got mis=%b valid=%b instr=%h pc=%h stall=%b expected 1 1 13 102 1",
                  o_misalign, o_instr_valid, o_instr, o_instr_pc, o_pc_stall);
      end
      flush  = 1'b1;
      target = 32'h104;
      step();
      flush = 1'b0;
      ready = 1'b1;
      #1;
      total++; if (o_misalign !== 1'b0 || o_instr_valid !== 1'b0) begin bad++; $display("FAIL ma_clear: got mis=%b valid=%b expected 0 0", o_misalign, o_instr_valid); end
   endtask
`endif

   task automatic test_drain();
      gnt_en = 1'b0;
      ready  = 1'b1;
      repeat (4) step();
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL drain: got %0d undelivered words expected 0", exp_q.size()); end
   endtask

   initial begin
      rst_n        = 1'b0;
      flush        = 1'b0;
      target       = '0;
      gnt_en       = 1'b1;
      ready        = 1'b1;
      lat          = 1;
      pc_force     = 1'b0;
      pc_force_val = '0;
      test_reset();
      test_first_fetch();
      test_hold();
      test_back_to_back();
      test_flush_wait();
      test_flush_req();
      test_reset_mid_wait();
`ifdef IFETCH_MISALIGN_CHECK_EN
      test_misalign();
`endif
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
